// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv_pkg
// Description : Shared RV32I opcodes, ALU codes, field widths and funct3->ALU map.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int INSTR_W   = 32;
    localparam int OPCODE_W  = 7;
    localparam int REG_IDX_W = 5;
    localparam int ALU_CODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd9;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [ALU_CODE_W-1:0] alu_from_funct3(input logic [2:0] f3,
                                                              input logic       alt);
        logic [ALU_CODE_W-1:0] r_code;
        case (f3)
            3'b000:  r_code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r_code = ALU_SLL;
            3'b010:  r_code = ALU_SLT;
            3'b011:  r_code = ALU_SLTU;
            3'b100:  r_code = ALU_XOR;
            3'b101:  r_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r_code = ALU_OR;
            default: r_code = ALU_AND;
        endcase
        return r_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : rv_decode_stage_if
// Description : Fetch-side and execute-side handshakes plus decoded bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4
);
    import rv_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   instr;
    logic [XLEN-1:0]      pc_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      pc_out;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [XLEN-1:0]      imm;
    logic [ALU_W-1:0]     alucontrol;
    logic                 reg_write;
    logic                 alu_src_imm;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic                 jump;
    logic                 illegal;

    modport master (
        output in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, rd, rs1, rs2, imm, alucontrol,
               reg_write, alu_src_imm, mem_read, mem_write, branch, jump, illegal
    );

    modport slave (
        input  in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, pc_out, rd, rs1, rs2, imm, alucontrol,
               reg_write, alu_src_imm, mem_read, mem_write, branch, jump, illegal
    );
endinterface
`default_nettype wire

// File: rtl/rv_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : rv_imm_gen
// Description : Combinational RV32I immediate extraction, sign-extended to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [INSTR_W-1:0] i_instr,
    output logic      [XLEN-1:0]    o_imm
);

    logic [31:0] w_raw;
    logic        w_s;

    assign w_s = i_instr[31];

    always_comb begin
        w_raw = '0;
        case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: w_raw = {{20{w_s}}, i_instr[31:20]};
            OP_STORE:                 w_raw = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
            OP_BRANCH:                w_raw = {{19{w_s}}, i_instr[31], i_instr[7],
                                               i_instr[30:25], i_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         w_raw = {i_instr[31:12], 12'b0};
            OP_JAL:                   w_raw = {{11{w_s}}, i_instr[31], i_instr[19:12],
                                               i_instr[20], i_instr[30:21], 1'b0};
            default:                  w_raw = '0;
        endcase
    end

    // Every format already carries instr[31] in bit 31, so one signed widen covers XLEN=64
    assign o_imm = XLEN'($signed(w_raw));

endmodule
`default_nettype wire

// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : rv_decode_stage
// Description : Registered RV32I decode stage with valid/ready on both sides,
//               flush, and an optional 2-entry skid for full-rate back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SKID_BUF = 0,
    parameter int ALU_W    = 4
) (
    input wire logic          clk,
    input wire logic          rst,
    input wire logic          flush,
    rv_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [ALU_W-1:0]     alu;
        logic                 reg_write;
        logic                 alu_src_imm;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 illegal;
    } bundle_t;

    logic [OPCODE_W-1:0]   w_opcode;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [XLEN-1:0]       w_imm;
    logic [ALU_CODE_W-1:0] w_alu;
    logic                  w_ill, w_rw, w_src, w_mr, w_mw, w_br, w_jmp, w_rs1_zero;
    bundle_t               w_dec;
    logic                  w_accept;

    bundle_t               r_out;
    logic                  r_out_valid;

    assign w_opcode = bus.instr[6:0];
    assign w_f3     = bus.instr[14:12];
    assign w_f7     = bus.instr[31:25];

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (bus.instr),
        .o_imm   (w_imm)
    );

    always_comb begin
        w_alu      = ALU_ADD;
        w_ill      = 1'b0;
        w_rw       = 1'b0;
        w_src      = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        w_br       = 1'b0;
        w_jmp      = 1'b0;
        w_rs1_zero = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_alu = alu_from_funct3(w_f3, w_f7[5]);
                w_rw  = 1'b1;
                w_ill = (w_f7 != F7_BASE && w_f7 != F7_ALT) ||
                        (w_f7 == F7_ALT && w_f3 != 3'b000 && w_f3 != 3'b101);
            end
            OP_IMM: begin
                // instr[30] only distinguishes SRAI from SRLI
                w_alu = alu_from_funct3(w_f3, (w_f3 == 3'b101) && bus.instr[30]);
                w_rw  = 1'b1;
                w_src = 1'b1;
                w_ill = (w_f3 == 3'b001 && w_f7 != F7_BASE) ||
                        (w_f3 == 3'b101 && w_f7 != F7_BASE && w_f7 != F7_ALT);
            end
            OP_LOAD: begin
                w_rw  = 1'b1;
                w_src = 1'b1;
                w_mr  = 1'b1;
                w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                w_src = 1'b1;
                w_mw  = 1'b1;
                w_ill = (w_f3 > 3'b010);
            end
            OP_BRANCH: begin
                w_br = 1'b1;
                case (w_f3)
                    3'b000, 3'b001: w_alu = ALU_SUB;
                    3'b100, 3'b101: w_alu = ALU_SLT;
                    3'b110, 3'b111: w_alu = ALU_SLTU;
                    default:        w_ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                w_rw       = 1'b1;
                w_src      = 1'b1;
                w_rs1_zero = 1'b1;
            end
            OP_AUIPC: begin
                w_rw  = 1'b1;
                w_src = 1'b1;
            end
            OP_JAL: begin
                w_rw  = 1'b1;
                w_jmp = 1'b1;
            end
            OP_JALR: begin
                w_rw  = 1'b1;
                w_src = 1'b1;
                w_jmp = 1'b1;
                w_ill = (w_f3 != 3'b000);
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_dec             = '0;
        w_dec.pc          = bus.pc_in;
        w_dec.imm         = w_imm;
        w_dec.rd          = bus.instr[11:7];
        w_dec.rs1         = w_rs1_zero ? '0 : bus.instr[19:15];
        w_dec.rs2         = bus.instr[24:20];
        w_dec.alu         = ALU_W'(w_alu);
        w_dec.alu_src_imm = w_src;
        w_dec.illegal     = w_ill;
        w_dec.reg_write   = w_rw && !w_ill && (bus.instr[11:7] != '0);
        w_dec.mem_read    = w_mr && !w_ill;
        w_dec.mem_write   = w_mw && !w_ill;
        w_dec.branch      = w_br && !w_ill;
        w_dec.jump        = w_jmp && !w_ill;
    end

    assign w_accept = bus.in_valid && bus.in_ready;

    generate
        if (SKID_BUF == 0) begin : g_single
            assign bus.in_ready = !r_out_valid || bus.out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out       <= '0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out       <= w_dec;
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            bundle_t r_skid;
            logic    r_skid_valid;

            // Registered ready: the skid entry absorbs the one bundle accepted while stalled
            assign bus.in_ready = !r_skid_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid  <= 1'b0;
                    r_out        <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid       <= '0;
                end else if (flush) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (r_out_valid && !bus.out_ready) begin
                    if (w_accept) begin
                        r_skid       <= w_dec;
                        r_skid_valid <= 1'b1;
                    end
                end else if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.out_valid   = r_out_valid;
    assign bus.pc_out      = r_out.pc;
    assign bus.rd          = r_out.rd;
    assign bus.rs1         = r_out.rs1;
    assign bus.rs2         = r_out.rs2;
    assign bus.imm         = r_out.imm;
    assign bus.alucontrol  = r_out.alu;
    assign bus.reg_write   = r_out.reg_write;
    assign bus.alu_src_imm = r_out.alu_src_imm;
    assign bus.mem_read    = r_out.mem_read;
    assign bus.mem_write   = r_out.mem_write;
    assign bus.branch      = r_out.branch;
    assign bus.jump        = r_out.jump;
    assign bus.illegal     = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_decode_stage
// Description : Directed bench for rv_decode_stage, no-skid and skid variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_decode_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(32), .ALU_W(4)) bus0 ();
    rv_decode_stage_if #(.XLEN(32), .ALU_W(4)) bus1 ();

    rv_decode_stage #(.XLEN(32), .SKID_BUF(0), .ALU_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0)
    );
    rv_decode_stage #(.XLEN(32), .SKID_BUF(1), .ALU_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1)
    );

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi(input int k);
        return {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    // Inputs stay still between the falling and rising edge, so a negedge view is the handshake
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (bus0.out_valid && bus0.out_ready) q0.push_back(bus0.imm);
            if (bus1.out_valid && bus1.out_ready) q1.push_back(bus1.imm);
        end
    end

    task automatic issue(input logic [31:0] ins);
        bus0.in_valid = 1'b1;
        bus0.instr    = ins;
        bus0.pc_in    = pc;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        pc = pc + 32'd4;
    endtask

    // flags = {reg_write, alu_src_imm, mem_read, mem_write, branch, jump, illegal}
    task automatic expect_out(input string tag, input logic [3:0] alu, input logic [31:0] imm,
                              input logic [6:0] flags, input logic [4:0] rd);
        check({tag, ".valid"}, 32'(bus0.out_valid), 32'd1);
        check({tag, ".alu"},   32'(bus0.alucontrol), 32'(alu));
        check({tag, ".imm"},   bus0.imm, imm);
        check({tag, ".flags"}, 32'({bus0.reg_write, bus0.alu_src_imm, bus0.mem_read,
                                    bus0.mem_write, bus0.branch, bus0.jump, bus0.illegal}),
              32'(flags));
        check({tag, ".rd"},    32'(bus0.rd), 32'(rd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int idx0, idx1, stall0, stall1;
        logic acc0, acc1;

        rst = 1'b1;
        flush = 1'b0;
        bus0.in_valid = 1'b0; bus0.instr = '0; bus0.pc_in = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.instr = '0; bus1.pc_in = '0; bus1.out_ready = 1'b1;
        pc = 32'h1000;

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid0", 32'(bus0.out_valid), 32'd0);
        check("reset.valid1", 32'(bus1.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("reset.in_ready0", 32'(bus0.in_ready), 32'd1);
        check("reset.in_ready1", 32'(bus1.in_ready), 32'd1);

        // Directed decode on the no-skid stage, back-to-back with out_ready high
        issue(32'h40208033);
        expect_out("sub_rd0", 4'd1, 32'h0, 7'b0000000, 5'd0);
        issue(32'h402081B3);
        expect_out("sub", 4'd1, 32'h0, 7'b1000000, 5'd3);
        check("sub.rs1", 32'(bus0.rs1), 32'd1);
        check("sub.rs2", 32'(bus0.rs2), 32'd2);
        check("sub.pc",  bus0.pc_out, 32'h1004);
        issue(32'h40000093);
        expect_out("addi_b30", 4'd0, 32'h400, 7'b1100000, 5'd1);
        issue(32'h4030D093);
        expect_out("srai", 4'd7, 32'h403, 7'b1100000, 5'd1);
        issue(32'hFE000EE3);
        expect_out("beq", 4'd1, 32'hFFFFFFFC, 7'b0000100, 5'd29);
        issue(32'h00004063);
        expect_out("blt", 4'd9, 32'h0, 7'b0000100, 5'd0);
        issue(32'h123452B7);
        expect_out("lui", 4'd0, 32'h12345000, 7'b1100000, 5'd5);
        check("lui.rs1", 32'(bus0.rs1), 32'd0);
        issue(32'h0040006F);
        expect_out("jal", 4'd0, 32'h4, 7'b0000010, 5'd0);
        issue(32'h00112223);
        expect_out("sw", 4'd0, 32'h4, 7'b0101000, 5'd4);
        issue(32'h0000C003);
        expect_out("lbu", 4'd0, 32'h0, 7'b0110000, 5'd0);
        issue(32'h0000E003);
        expect_out("ill_load", 4'd0, 32'h0, 7'b0100001, 5'd0);
        issue(32'h0000007F);
        expect_out("ill_op", 4'd0, 32'h0, 7'b0000001, 5'd0);
        issue(32'h4000F0B3);
        expect_out("ill_r", 4'd2, 32'h0, 7'b0000001, 5'd1);
        issue(32'h40001093);
        expect_out("ill_slli", 4'd5, 32'h400, 7'b0100001, 5'd1);

        // Asynchronous reset while a bundle is held
        bus0.out_ready = 1'b0;
        issue(32'h402081B3);
        check("rstmid.held", 32'(bus0.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid.valid", 32'(bus0.out_valid), 32'd0);
        check("rstmid.imm",   bus0.imm, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstmid.in_ready", 32'(bus0.in_ready), 32'd1);
        check("rstmid.after_valid", 32'(bus0.out_valid), 32'd0);

        // Back-pressure stream with out_ready toggling
        q0.delete(); q1.delete();
        idx0 = 0; idx1 = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 80 && !(q0.size() == 8 && q1.size() == 8); c++) begin
            bus0.in_valid = (idx0 < 8); bus0.instr = addi(idx0); bus0.out_ready = (c % 2 == 0);
            bus1.in_valid = (idx1 < 8); bus1.instr = addi(idx1); bus1.out_ready = (c % 2 == 0);
            @(negedge clk);
            acc0 = bus0.in_valid && bus0.in_ready;
            acc1 = bus1.in_valid && bus1.in_ready;
            @(posedge clk); #1;
            if (acc0) idx0++;
            if (acc1) idx1++;
        end
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        check("stream0.count", 32'(q0.size()), 32'd8);
        check("stream1.count", 32'(q1.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("stream0.order", (i < q0.size()) ? q0[i] : 32'hDEAD, 32'(i));
            check("stream1.order", (i < q1.size()) ? q1[i] : 32'hDEAD, 32'(i));
        end

        // Full rate with out_ready held high
        q0.delete(); q1.delete();
        stall0 = 0; stall1 = 0;
        bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus0.in_valid = 1'b1; bus0.instr = addi(16 + k);
            bus1.in_valid = 1'b1; bus1.instr = addi(16 + k);
            @(negedge clk);
            if (!bus0.in_ready) stall0++;
            if (!bus1.in_ready) stall1++;
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rate0.stalls", 32'(stall0), 32'd0);
        check("rate1.stalls", 32'(stall1), 32'd0);
        check("rate1.count",  32'(q1.size()), 32'd8);
        check("rate1.last",   (q1.size() == 8) ? q1[7] : 32'hDEAD, 32'd23);

        // Flush with skid full, held output, and an input offered in the flush cycle
        q0.delete(); q1.delete();
        bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.instr = addi(100);
        bus1.in_valid = 1'b1; bus1.instr = addi(100);
        @(posedge clk); #1;
        bus0.instr = addi(101);
        bus1.instr = addi(101);
        @(posedge clk); #1;
        check("flush.skid_full", 32'(bus1.in_ready), 32'd0);
        check("flush.held_imm",  bus1.imm, 32'd100);
        flush = 1'b1;
        bus0.instr = addi(102); bus0.out_ready = 1'b1;
        bus1.instr = addi(102);
        @(posedge clk); #1;
        flush = 1'b0;
        bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
        check("flush.valid0", 32'(bus0.out_valid), 32'd0);
        check("flush.valid1", 32'(bus1.out_valid), 32'd0);
        check("flush.in_ready1", 32'(bus1.in_ready), 32'd1);
        bus1.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush.drop0", 32'(q0.size()), 32'd0);
        check("flush.drop1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
